// File: rtl/washer_pkg.sv
// rtl/washer_pkg.sv - shared button indices, hold-FSM encodings and helpers
package washer_pkg;

    localparam int BTN_RESET = 0;
    localparam int BTN_RUN   = 1;
    localparam int BTN_WATER = 2;
    localparam int BTN_OPEN  = 3;
    localparam int BTN_CLICK = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } hold_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw pad inputs and conditioned button outputs
interface button_conditioner_if #(
    parameter int NUM_BTNS = 5
);
    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;
    logic [NUM_BTNS-1:0] btn_release;
    logic [NUM_BTNS-1:0] btn_long;
    logic [NUM_BTNS-1:0] btn_repeat;

    modport master (
        output btn_raw,
        input  btn_level, btn_press, btn_release, btn_long, btn_repeat
    );

    modport slave (
        input  btn_raw,
        output btn_level, btn_press, btn_release, btn_long, btn_repeat
    );
endinterface

// File: rtl/button_channel.sv
// rtl/button_channel.sv - one button: 2-flop sync, debounce and press/long/repeat FSM
module button_channel
    import washer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 64,
    parameter int REPEAT_CYCLES   = 8,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int CW = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES));

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          press_q, release_q, long_q, repeat_q;
    logic [DW-1:0] db_cnt_q;
    logic [CW-1:0] hold_cnt_q;
    hold_state_e   state_q;
    logic          db_fire;

    assign db_fire = (s2_q != level_q) && (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1));
    assign level_d = db_fire ? s2_q : level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            repeat_q   <= 1'b0;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            state_q    <= IDLE;
        end else begin
            s1_q      <= raw_i;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= db_fire & s2_q;
            release_q <= db_fire & ~s2_q;
            repeat_q  <= 1'b0;

            if ((s2_q == level_q) || db_fire)
                db_cnt_q <= '0;
            else
                db_cnt_q <= db_cnt_q + DW'(1);

            // A release wins over any long/repeat event due on the same edge
            if (db_fire && !s2_q) begin
                state_q    <= IDLE;
                long_q     <= 1'b0;
                hold_cnt_q <= '0;
            end else if (db_fire && s2_q) begin
                state_q    <= PRESSED;
                hold_cnt_q <= '0;
            end else begin
                case (state_q)
                    PRESSED: begin
                        if (hold_cnt_q == CW'(LONG_CYCLES - 1)) begin
                            state_q    <= HELD;
                            long_q     <= 1'b1;
                            repeat_q   <= REPEAT_EN;
                            hold_cnt_q <= '0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + CW'(1);
                        end
                    end
                    HELD: begin
                        if (hold_cnt_q == CW'(REPEAT_CYCLES - 1)) begin
                            repeat_q   <= REPEAT_EN;
                            hold_cnt_q <= '0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + CW'(1);
                        end
                    end
                    default: hold_cnt_q <= '0;
                endcase
            end
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign repeat_o  = repeat_q;
endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - washer panel button front end, one channel per button
module button_conditioner
    import washer_pkg::*;
#(
    parameter int                  NUM_BTNS        = 5,
    parameter int                  DEBOUNCE_CYCLES = 16,
    parameter int                  LONG_CYCLES     = 64,
    parameter int                  REPEAT_CYCLES   = 8,
    parameter logic [NUM_BTNS-1:0] REPEAT_MASK     = NUM_BTNS'(1) << BTN_CLICK
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);
    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (REPEAT_MASK[g])
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .raw_i     (bus.btn_raw[g]),
            .level_o   (bus.btn_level[g]),
            .press_o   (bus.btn_press[g]),
            .release_o (bus.btn_release[g]),
            .long_o    (bus.btn_long[g]),
            .repeat_o  (bus.btn_repeat[g])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed bench for button_conditioner
module tb_button_conditioner;
    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;

    button_conditioner_if #(.NUM_BTNS(5)) bus();

    button_conditioner #(
        .NUM_BTNS        (5),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (8),
        .REPEAT_CYCLES   (3),
        .REPEAT_MASK     (5'b10000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset with all buttons held, then fresh press after debounce
        reset = 1'b1;
        bus.btn_raw = 5'b11111;
        step(3);
        chk("rst_level",   bus.btn_level,   5'b00000);
        chk("rst_press",   bus.btn_press,   5'b00000);
        chk("rst_release", bus.btn_release, 5'b00000);
        chk("rst_long",    bus.btn_long,    5'b00000);
        chk("rst_repeat",  bus.btn_repeat,  5'b00000);
        reset = 1'b0;
        step(5);
        chk("t1_level_e5", bus.btn_level, 5'b00000);
        chk("t1_press_e5", bus.btn_press, 5'b00000);
        step(1);
        chk("t1_level_e6", bus.btn_level, 5'b11111);
        chk("t1_press_e6", bus.btn_press, 5'b11111);
        step(1);
        chk("t1_press_e7", bus.btn_press, 5'b00000);
        bus.btn_raw = 5'b00000;
        step(5);
        chk("t1_level_hold", bus.btn_level,   5'b11111);
        chk("t1_rel_early",  bus.btn_release, 5'b00000);
        step(1);
        chk("t1_release", bus.btn_release, 5'b11111);
        chk("t1_level0",  bus.btn_level,   5'b00000);
        chk("t1_long0",   bus.btn_long,    5'b00000);
        step(2);

        // 2: bounce then settle, followed by a 3-cycle glitch
        bus.btn_raw = 5'b00010; step(1); chk("t2_bounce", bus.btn_press, 5'b00000);
        bus.btn_raw = 5'b00000; step(1); chk("t2_bounce", bus.btn_press, 5'b00000);
        bus.btn_raw = 5'b00010; step(1); chk("t2_bounce", bus.btn_press, 5'b00000);
        bus.btn_raw = 5'b00000; step(1); chk("t2_bounce", bus.btn_press, 5'b00000);
        bus.btn_raw = 5'b00010;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t2_no_press", bus.btn_press, 5'b00000);
        end
        step(1);
        chk("t2_press", bus.btn_press, 5'b00010);
        step(1);
        chk("t2_press_once", bus.btn_press, 5'b00000);
        bus.btn_raw = 5'b00000;
        step(6);
        chk("t2_release", bus.btn_release, 5'b00010);
        chk("t2_long0",   bus.btn_long,    5'b00000);
        step(2);
        bus.btn_raw = 5'b00010;
        step(3);
        bus.btn_raw = 5'b00000;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("t2_glitch_press", bus.btn_press, 5'b00000);
            chk("t2_glitch_level", bus.btn_level, 5'b00000);
        end

        // 3: long press and auto-repeat on click
        bus.btn_raw = 5'b10000;
        step(6);
        chk("t3_press", bus.btn_press, 5'b10000);
        step(7);
        chk("t3_long_t7",   bus.btn_long,   5'b00000);
        chk("t3_repeat_t7", bus.btn_repeat, 5'b00000);
        step(1);
        chk("t3_long_t8",   bus.btn_long,   5'b10000);
        chk("t3_repeat_t8", bus.btn_repeat, 5'b10000);
        step(1);
        chk("t3_repeat_t9", bus.btn_repeat, 5'b00000);
        step(2);
        chk("t3_repeat_t11", bus.btn_repeat, 5'b10000);
        step(3);
        chk("t3_repeat_t14", bus.btn_repeat, 5'b10000);
        step(3);
        chk("t3_repeat_t17", bus.btn_repeat, 5'b10000);
        step(6);
        chk("t3_repeat_t23", bus.btn_repeat, 5'b10000);
        step(1);
        bus.btn_raw = 5'b00000;
        step(5);
        chk("t3_repeat_t29", bus.btn_repeat, 5'b10000);
        chk("t3_long_t29",   bus.btn_long,   5'b10000);
        step(1);
        chk("t3_release", bus.btn_release, 5'b10000);
        chk("t3_long_off", bus.btn_long,   5'b00000);
        chk("t3_rep_off",  bus.btn_repeat, 5'b00000);
        step(2);

        // 4: unmasked channel gets long but never repeat
        bus.btn_raw = 5'b00100;
        step(6);
        chk("t4_press", bus.btn_press, 5'b00100);
        step(7);
        chk("t4_long_t7", bus.btn_long, 5'b00000);
        step(1);
        chk("t4_long_t8",   bus.btn_long,   5'b00100);
        chk("t4_repeat_t8", bus.btn_repeat, 5'b00000);
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("t4_repeat", bus.btn_repeat, 5'b00000);
        end
        bus.btn_raw = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t4_repeat", bus.btn_repeat, 5'b00000);
        end
        step(1);
        chk("t4_release", bus.btn_release, 5'b00100);
        chk("t4_long_off", bus.btn_long,   5'b00000);
        step(2);

        // 5: release landing on a repeat edge, then simultaneous presses
        bus.btn_raw = 5'b10000;
        step(6);
        chk("t5_press", bus.btn_press, 5'b10000);
        step(8);
        chk("t5_repeat_t8", bus.btn_repeat, 5'b10000);
        bus.btn_raw = 5'b00000;
        step(3);
        chk("t5_repeat_t11", bus.btn_repeat, 5'b10000);
        step(2);
        chk("t5_repeat_t13", bus.btn_repeat, 5'b00000);
        step(1);
        chk("t5_release", bus.btn_release, 5'b10000);
        chk("t5_no_rep",  bus.btn_repeat,  5'b00000);
        chk("t5_long0",   bus.btn_long,    5'b00000);
        step(2);
        bus.btn_raw = 5'b01001;
        step(6);
        chk("t5_dual_press", bus.btn_press, 5'b01001);
        bus.btn_raw = 5'b00000;
        step(6);
        chk("t5_dual_rel", bus.btn_release, 5'b01001);
        step(2);

        // 6: reset while held clears long silently, then re-press
        bus.btn_raw = 5'b10000;
        step(6);
        chk("t6_press", bus.btn_press, 5'b10000);
        step(9);
        chk("t6_long_held", bus.btn_long, 5'b10000);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_long_rst",  bus.btn_long,    5'b00000);
        chk("t6_rel_rst",   bus.btn_release, 5'b00000);
        chk("t6_level_rst", bus.btn_level,   5'b00000);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("t6_no_rel", bus.btn_release, 5'b00000);
        end
        step(1);
        chk("t6_repress", bus.btn_press, 5'b10000);
        bus.btn_raw = 5'b00000;
        step(6);
        chk("t6_release", bus.btn_release, 5'b10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
